// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between icache reads, dcache reads and dcache writebacks.
// One transaction in flight; the icache is forced through after STARVE_LIMIT lost arbitrations.
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  input  logic [LEN_W-1:0]  ic_rd_len,
  output logic              ic_rd_gnt,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  input  logic [LEN_W-1:0]  dc_rd_len,
  output logic              dc_rd_gnt,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [LEN_W-1:0]  dc_wr_len,
  output logic              dc_wr_gnt,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic              dc_wr_pop,
  output logic              dc_wr_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              mem_addr_ok,
  input  logic              mem_rvalid,
  input  logic              mem_rlast,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wvalid,
  output logic              mem_wlast,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wready,
  input  logic              mem_bvalid
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC_RD, OWN_DC_WR} owner_e;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [LEN_W-1:0]  beat_q, beat_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, req_q, req_d, done_q, done_d;
  logic              ic_win, dc_any, rd_beat;
  logic [2:0]        pend_q, pend_d;

  assign dc_any = dc_wr_req | dc_rd_req;
  // icache wins outright when it is starved or alone
  assign ic_win = ic_rd_req & ((starve_q == STARVE_MAX) | ~dc_any);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    beat_d   = beat_q;
    len_d    = len_q;
    addr_d   = addr_q;
    we_d     = we_q;
    req_d    = req_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ic_win) begin
          owner_d = OWN_IC; addr_d = ic_rd_addr; len_d = ic_rd_len; we_d = 1'b0;
          req_d = 1'b1; state_d = RD_ADDR; starve_d = '0;
        end else if (dc_wr_req) begin
          owner_d = OWN_DC_WR; addr_d = dc_wr_addr; len_d = dc_wr_len; we_d = 1'b1;
          req_d = 1'b1; state_d = WR_ADDR;
        end else if (dc_rd_req) begin
          owner_d = OWN_DC_RD; addr_d = dc_rd_addr; len_d = dc_rd_len; we_d = 1'b0;
          req_d = 1'b1; state_d = RD_ADDR;
        end
        if (!ic_win && ic_rd_req && dc_any && starve_q != STARVE_MAX)
          starve_d = starve_q + 1'b1;
      end
      RD_ADDR: if (mem_addr_ok) begin req_d = 1'b0; state_d = RD_DATA; end
      RD_DATA: if (mem_rvalid && mem_rlast) begin state_d = IDLE; owner_d = OWN_NONE; end
      WR_ADDR: if (mem_addr_ok) begin req_d = 1'b0; beat_d = '0; state_d = WR_DATA; end
      WR_DATA: if (mem_wready) begin
        beat_d = beat_q + 1'b1;
        if (mem_wlast) state_d = WR_RESP;
      end
      WR_RESP: if (mem_bvalid) begin done_d = 1'b1; state_d = IDLE; owner_d = OWN_NONE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; owner_q <= OWN_NONE; starve_q <= '0; beat_q <= '0;
      len_q <= '0; addr_q <= '0; we_q <= 1'b0; req_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; owner_q <= owner_d; starve_q <= starve_d; beat_q <= beat_d;
      len_q <= len_d; addr_q <= addr_d; we_q <= we_d; req_q <= req_d; done_q <= done_d;
    end
  end

  assign mem_req  = req_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_len  = len_q;

  assign ic_rd_gnt = (state_q == RD_ADDR) & mem_addr_ok & (owner_q == OWN_IC);
  assign dc_rd_gnt = (state_q == RD_ADDR) & mem_addr_ok & (owner_q == OWN_DC_RD);
  assign dc_wr_gnt = (state_q == WR_ADDR) & mem_addr_ok;

  // Return data is gated so idle outputs stay at zero
  assign rd_beat      = (state_q == RD_DATA) & mem_rvalid;
  assign ic_ret_valid = rd_beat & (owner_q == OWN_IC);
  assign ic_ret_last  = ic_ret_valid & mem_rlast;
  assign ic_ret_data  = ic_ret_valid ? mem_rdata : '0;
  assign dc_ret_valid = rd_beat & (owner_q == OWN_DC_RD);
  assign dc_ret_last  = dc_ret_valid & mem_rlast;
  assign dc_ret_data  = dc_ret_valid ? mem_rdata : '0;

  assign mem_wvalid = (state_q == WR_DATA);
  assign mem_wlast  = mem_wvalid & (beat_q == len_q);
  assign mem_wdata  = mem_wvalid ? dc_wr_data : '0;
  assign dc_wr_pop  = mem_wvalid & mem_wready;
  assign dc_wr_done = done_q;

  // Requests seen last cycle but not granted must still be present
  assign pend_d = {dc_wr_req & ~dc_wr_gnt, dc_rd_req & ~dc_rd_gnt, ic_rd_req & ~ic_rd_gnt};
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else begin
      pend_q <= pend_d;
      assert ((pend_q & ~{dc_wr_req, dc_rd_req, ic_rd_req}) == 3'b000);
    end
  end
endmodule
